// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: opcode/funct constants, NOP encoding and the IF/ID payload.
// The control decoder imports the same package.
package fetch_stage_pkg;
    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_JAL   = 6'b000011,
        OP_BEQ   = 6'b000100
    } opcode_e;
    localparam logic [5:0]  FUNCT_JR         = 6'b001000;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        valid;
    } if_id_t;
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: EX control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_pred_taken;
    logic [31:0] if_id_pred_target;
    logic        if_id_valid;
    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_addr, if_id_instr, if_id_pc_plus4, if_id_pred_taken, if_id_pred_target, if_id_valid
    );
    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_pred_taken, if_id_pred_target, if_id_valid
    );
endinterface

// File: rtl/fetch_stage_ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] data_i,
    output logic [31:0] top_o,
    output logic        empty_o,
    output logic        full_o
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] ptr_q;
    logic [AW:0]   cnt_q;
    // ptr_q is the next free slot, so the top sits one below it.
    assign top_o   = mem_q[ptr_q - AW'(1)];
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i) begin
            mem_q[ptr_q] <= data_i;
            ptr_q        <= ptr_q + AW'(1);
            cnt_q        <= full_o ? cnt_q : cnt_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            ptr_q <= ptr_q - AW'(1);
            cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, static branch prediction and the IF/ID register.
// Define RAS_EN to predict JR $31 from a return-address stack.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter int          RAS_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of 2, at least 2");
    end
    logic [31:0] instr, pc_q, pc_d, pc_plus4, target, ras_top;
    logic [5:0]  op;
    logic        is_beq_bwd, is_j, ras_pop, pred_taken;
    if_id_t      if_id_q, if_id_d;
    assign instr      = bus.imem_rdata;
    assign op         = instr[31:26];
    assign pc_plus4   = pc_q + 32'd4;
    assign is_beq_bwd = op == OP_BEQ && instr[15];
    assign is_j       = op == OP_J || op == OP_JAL;
`ifdef RAS_EN
    logic advance, ras_empty;
    assign advance = !bus.redirect_valid && !bus.stall;
    // Only JR through $31 counts as a return.
    assign ras_pop = op == OP_RTYPE && instr[5:0] == FUNCT_JR && instr[25:21] == 5'd31 && !ras_empty;
    ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk    (clk),
        .reset  (reset),
        .push_i (advance && op == OP_JAL),
        .pop_i  (advance && ras_pop),
        .data_i (pc_plus4),
        .top_o  (ras_top),
        .empty_o(ras_empty),
        .full_o ()
    );
`else
    assign ras_pop = 1'b0;
    assign ras_top = pc_plus4;
`endif
    assign pred_taken = is_beq_bwd || is_j || ras_pop;
    assign target = is_beq_bwd ? pc_plus4 + br_offset(instr[15:0])
                  : is_j       ? {pc_plus4[31:28], instr[25:0], 2'b00}
                  : ras_pop    ? ras_top
                  :              pc_plus4;
    assign bus.imem_addr         = pc_q;
    assign bus.if_id_instr       = if_id_q.instr;
    assign bus.if_id_pc_plus4    = if_id_q.pc_plus4;
    assign bus.if_id_pred_taken  = if_id_q.pred_taken;
    assign bus.if_id_pred_target = if_id_q.pred_target;
    assign bus.if_id_valid       = if_id_q.valid;
    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;
        if (bus.redirect_valid) begin
            pc_d               = bus.redirect_pc & ~32'h3;
            if_id_d.instr      = NOP;
            if_id_d.pred_taken = 1'b0;
            if_id_d.valid      = 1'b0;
        end else if (!bus.stall) begin
            pc_d    = target;
            if_id_d = '{instr: instr, pc_plus4: pc_plus4, pred_taken: pred_taken,
                        pred_target: target, valid: 1'b1};
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_RESET & ~32'h3;
            if_id_q <= '0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end
endmodule
